sa_tile_scheduler: RTL
======================

// Module: sa_tile_scheduler
// PURPOSE
//  Sequences the 4x4 systolic PE array (row/column operand buffers, PE mesh, result taps) over a tiled GEMM job.
//  C[M x N] = A[M x K] * B[K x N], with M = m_tiles*ARR_DIM, N = n_tiles*ARR_DIM, K = K_SIZE.
//  For each output tile: load operands, clear, run the skewed compute wavefront, then drain the 16 results.
//  Sits between the host stream interface and the array. Drives buffer write selects, set_reg paths and the result mux.
// PARAMETERS
//  ARR_DIM    4   PE rows = PE columns; buffer count per operand
//  K_SIZE     4   inner dimension = beats per buffer row
//  TILE_W     4   width of tile-count config and tile index outputs
//  PERF_W     32  perf counter width (only with SA_SCHED_PERF_EN)
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          asynchronous active-low reset
//  start          in   1          job request; sampled only in IDLE
//  cfg_m_tiles    in   TILE_W     row-tile count; captured on accepted start
//  cfg_n_tiles    in   TILE_W     column-tile count; captured on accepted start
//  busy           out  1          high from accepted start until DONE
//  done           out  1          one-cycle pulse after last tile drained
//  ld_ready       out  1          high in LOAD; operand beat accepted when ld_valid && ld_ready
//  ld_valid       in   1          host operand beat valid
//  ld_sel_a       out  ARR_DIM    A-buffer write enable; [ARR_DIM-1] = A row 0
//  ld_sel_b       out  ARR_DIM    B-buffer write enable; [ARR_DIM-1] = B col 0
//  arr_clear      out  1          one-cycle PE accumulator clear
//  set_reg_path   out  2*ARR_DIM-1  anti-diagonal MAC enables; bit p feeds PEs with row+col == p
//  out_valid      out  1          result tap valid
//  out_ready      in   1          host accepts result
//  out_sel        out  4          result index, row-major (row*ARR_DIM + col)
//  tile_m         out  TILE_W     current row-tile index
//  tile_n         out  TILE_W     current column-tile index
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. Same response when reset is asserted mid-job (no completion, no done).
//  FSM: IDLE -> LOAD -> CLEAR -> COMPUTE -> DRAIN -> (LOAD of next tile | DONE) -> IDLE.
//  IDLE: start=1 latches cfg (a value of 0 is treated as 1), clears tile_m/tile_n, goes to LOAD next cycle.
//    start outside IDLE is ignored.
//  LOAD: row r = 0..2*ARR_DIM-1, beat k = 0..K_SIZE-1. Rows 0..ARR_DIM-1 are A rows; the remaining rows are B columns.
//    ld_sel_a[ARR_DIM-1-r] = ld_valid for r < ARR_DIM, otherwise 0.
//    ld_sel_b[2*ARR_DIM-1-r] = ld_valid for r >= ARR_DIM, otherwise 0. Selects are combinational, at most one-hot.
//    ld_valid=0 stalls without advancing. After 2*ARR_DIM*K_SIZE accepted beats (32 at defaults) -> CLEAR.
//  CLEAR: arr_clear=1 for exactly one cycle -> COMPUTE.
//  COMPUTE: cycle counter c = 0..K_SIZE+2*ARR_DIM-2 (11 cycles at defaults).
//    set_reg_path[p] = 1 iff p <= c < p+K_SIZE. The final cycle is a flush cycle with all paths 0. Then -> DRAIN.
//  DRAIN: out_valid=1, out_sel walks 0..ARR_DIM*ARR_DIM-1. Advance only on out_valid && out_ready.
//    out_ready=0 holds out_sel stable. Transfer of index 15 ends the tile.
//  Tile advance: tile_n++. When tile_n wraps at n_tiles: tile_n=0, tile_m++.
//    After the last tile (tile_m=m_tiles-1, tile_n=n_tiles-1) -> DONE; otherwise -> LOAD.
//  DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE. start in that cycle is ignored.
//  busy is registered: 1 in the cycle after start is accepted, through the last DRAIN cycle.
//  No input affects COMPUTE or CLEAR; ld_valid and out_ready are ignored outside LOAD and DRAIN.
// CONFIGURATION
//  SA_SCHED_PERF_EN defined: adds outputs perf_busy [PERF_W] and perf_stall [PERF_W].
//    Both clear on accepted start, saturate at all-ones, and hold after done.
//    perf_busy counts cycles with busy=1.
//    perf_stall counts LOAD cycles with ld_valid=0 plus DRAIN cycles with out_ready=0.
//  SA_SCHED_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 single tile, cfg 1/1, ld_valid and out_ready tied 1:
//    32 load beats; arr_clear 1 cycle; set_reg_path[0] high at c=0..3 and [6] at c=6..9;
//    16 drain beats; done 1 cycle; total time start->done = 1+32+1+11+16 cycles.
//  T2 load select order: ld_sel_a goes 1000, 0100, 0010, 0001 (4 beats each), then ld_sel_b in the same order.
//    Toggling ld_valid 1/0 gives zero selects on the 0 cycles and 64 cycles in LOAD.
//  T3 drain backpressure: out_ready low for 5 cycles at out_sel=7 -> out_sel holds 7, out_valid stays 1,
//    no skipped or duplicate indices.
//  T4 multi-tile cfg 2/3 -> tile (m,n) order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); 6 arr_clear pulses; one done.
//  T5 rst_n low in COMPUTE at c=3 -> all outputs 0 at once; no done.
//    A new start afterwards completes normally. A start pulse while busy has no effect.
//  T6 with SA_SCHED_PERF_EN, T1 plus 5 ld_valid gaps and 3 out_ready gaps -> perf_stall=8, perf_busy=T1 count+8.

Source files
------------

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for a 4x4 systolic GEMM array: load operands, clear, skewed compute, drain.
// Optional perf counters (perf_busy, perf_stall) are built when SA_SCHED_PERF_EN is defined.
module sa_tile_scheduler #(
    parameter int ARR_DIM = 4,
    parameter int K_SIZE  = 4,
    parameter int TILE_W  = 4,
    parameter int PERF_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [TILE_W-1:0]    cfg_m_tiles,
    input  logic [TILE_W-1:0]    cfg_n_tiles,
    output logic                 busy,
    output logic                 done,
    output logic                 ld_ready,
    input  logic                 ld_valid,
    output logic [ARR_DIM-1:0]   ld_sel_a,
    output logic [ARR_DIM-1:0]   ld_sel_b,
    output logic                 arr_clear,
    output logic [2*ARR_DIM-2:0] set_reg_path,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_sel,
    output logic [TILE_W-1:0]    tile_m,
    output logic [TILE_W-1:0]    tile_n
`ifdef SA_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_busy,
    output logic [PERF_W-1:0]    perf_stall
`endif
);

    localparam int ROWS     = 2 * ARR_DIM;
    localparam int COMP_LEN = K_SIZE + 2 * ARR_DIM - 1;
    localparam int OUTS     = ARR_DIM * ARR_DIM;
    localparam int CNT_W    = $clog2((COMP_LEN > OUTS ? COMP_LEN : OUTS) + 1);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int BEAT_W   = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t             state, next_state;
    logic [TILE_W-1:0]  m_tiles, n_tiles;
    logic [ROW_W-1:0]   ld_row;
    logic [BEAT_W-1:0]  ld_beat;
    logic [CNT_W-1:0]   cnt;

    logic ld_fire, load_last, comp_last, out_fire, drain_last, tile_last;

    assign ld_fire    = (state == S_LOAD) && ld_valid;
    assign load_last  = ld_fire && (ld_row == ROW_W'(ROWS - 1)) && (ld_beat == BEAT_W'(K_SIZE - 1));
    assign comp_last  = (state == S_COMPUTE) && (cnt == CNT_W'(COMP_LEN - 1));
    assign out_fire   = (state == S_DRAIN) && out_ready;
    assign drain_last = out_fire && (cnt == CNT_W'(OUTS - 1));
    assign tile_last  = (tile_m == m_tiles - 1'b1) && (tile_n == n_tiles - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_LOAD;
            S_LOAD:    if (load_last) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_COMPUTE;
            S_COMPUTE: if (comp_last) next_state = S_DRAIN;
            S_DRAIN:   if (drain_last) next_state = tile_last ? S_DONE : S_LOAD;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == S_LOAD) || (state == S_CLEAR) ||
                       (state == S_COMPUTE) || (state == S_DRAIN);
        done         = (state == S_DONE);
        ld_ready     = (state == S_LOAD);
        arr_clear    = (state == S_CLEAR);
        out_valid    = (state == S_DRAIN);
        out_sel      = (state == S_DRAIN) ? 4'(cnt) : 4'd0;
        ld_sel_a     = '0;
        ld_sel_b     = '0;
        set_reg_path = '0;
        // Row 0 of each operand maps to the MSB select.
        for (int i = 0; i < ARR_DIM; i++) begin
            if (ld_fire && int'(ld_row) == ARR_DIM - 1 - i) ld_sel_a[i] = 1'b1;
            if (ld_fire && int'(ld_row) == ROWS - 1 - i)    ld_sel_b[i] = 1'b1;
        end
        // Anti-diagonal p is live for K_SIZE cycles starting at c == p.
        for (int p = 0; p < 2 * ARR_DIM - 1; p++) begin
            if (state == S_COMPUTE && int'(cnt) >= p && int'(cnt) < p + K_SIZE)
                set_reg_path[p] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tiles <= '0;
            n_tiles <= '0;
            tile_m  <= '0;
            tile_n  <= '0;
            ld_row  <= '0;
            ld_beat <= '0;
            cnt     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                m_tiles <= (cfg_m_tiles == '0) ? TILE_W'(1) : cfg_m_tiles;
                n_tiles <= (cfg_n_tiles == '0) ? TILE_W'(1) : cfg_n_tiles;
                tile_m  <= '0;
                tile_n  <= '0;
                ld_row  <= '0;
                ld_beat <= '0;
            end
            if (load_last) begin
                ld_row  <= '0;
                ld_beat <= '0;
            end else if (ld_fire) begin
                if (ld_beat == BEAT_W'(K_SIZE - 1)) begin
                    ld_beat <= '0;
                    ld_row  <= ld_row + 1'b1;
                end else begin
                    ld_beat <= ld_beat + 1'b1;
                end
            end
            // cnt is the compute cycle in COMPUTE and the result index in DRAIN.
            if (state != next_state)
                cnt <= '0;
            else if (state == S_COMPUTE || out_fire)
                cnt <= cnt + 1'b1;
            if (drain_last && !tile_last) begin
                if (tile_n == n_tiles - 1'b1) begin
                    tile_n <= '0;
                    tile_m <= tile_m + 1'b1;
                end else begin
                    tile_n <= tile_n + 1'b1;
                end
            end
        end
    end

`ifdef SA_SCHED_PERF_EN
    logic stall;
    assign stall = ((state == S_LOAD) && !ld_valid) || ((state == S_DRAIN) && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (state == S_IDLE && start) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && perf_busy != '1)   perf_busy  <= perf_busy + 1'b1;
            if (stall && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule
